// File: rtl/idecode_if.sv
// Fetch-to-decode-to-execute signal bundle for the idecode stage.
// The slave modport is the decoder's view. The master modport is the surrounding pipeline's view.
interface idecode_if #(
  parameter int unsigned WORD = 32
);
  logic            v_i;
  logic [WORD-1:0] inst_i;
  logic            stall_o;
  logic            stall_i;
  logic            flush_i;
  logic            v_o;
  logic [5:0]      op_o;
  logic [4:0]      rs_o;
  logic [4:0]      rt_o;
  logic [4:0]      rd_o;
  logic [WORD-1:0] imm_o;
  logic            load_o;
  logic [15:0]     hcnt_o;

  modport slave (
    input  v_i, inst_i, stall_i, flush_i,
    output stall_o, v_o, op_o, rs_o, rt_o, rd_o, imm_o, load_o, hcnt_o
  );

  modport master (
    output v_i, inst_i, stall_i, flush_i,
    input  stall_o, v_o, op_o, rs_o, rt_o, rd_o, imm_o, load_o, hcnt_o
  );
endinterface

// File: rtl/idecode.sv
// Single-register instruction decode stage.
// It detects load-use hazards, inserts one bubble per hazard and counts the bubbles it inserts.
module idecode #(
  parameter int unsigned WORD = 32
) (
  input  logic     clk,
  input  logic     rst,
  idecode_if.slave bus
);

  localparam logic [5:0] OpLoad = 6'b100011;

  logic            r_v;
  logic [5:0]      r_op;
  logic [4:0]      r_rs;
  logic [4:0]      r_rt;
  logic [4:0]      r_rd;
  logic [WORD-1:0] r_imm;
  logic            r_load;
  logic [15:0]     r_hcnt;

  logic            w_hazard;
  logic            w_accept;
  logic [5:0]      w_op;
  logic [WORD-1:0] w_imm;

  assign w_op  = bus.inst_i[31:26];
  assign w_imm = {{(WORD-16){bus.inst_i[15]}}, bus.inst_i[15:0]};

  // A load into r0 never creates a dependency.
  assign w_hazard = bus.v_i & r_v & r_load & (r_rt != 5'd0) &
                    ((r_rt == bus.inst_i[25:21]) | (r_rt == bus.inst_i[20:16]));
  assign w_accept = ~bus.stall_i | ~r_v;

  always_comb begin
    bus.stall_o = ~bus.flush_i & ((r_v & bus.stall_i) | (w_accept & w_hazard));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v    <= 1'b0;
      r_op   <= '0;
      r_rs   <= '0;
      r_rt   <= '0;
      r_rd   <= '0;
      r_imm  <= '0;
      r_load <= 1'b0;
      r_hcnt <= '0;
    end else if (bus.flush_i) begin
      r_v    <= 1'b0;
      r_load <= 1'b0;
    end else if (w_accept) begin
      if (w_hazard) begin
        // Clearing load makes the held consumer go through on the next cycle.
        r_v    <= 1'b0;
        r_load <= 1'b0;
        if (r_hcnt != 16'hFFFF) begin
          r_hcnt <= r_hcnt + 16'd1;
        end
      end else begin
        r_v    <= bus.v_i;
        r_op   <= w_op;
        r_rs   <= bus.inst_i[25:21];
        r_rt   <= bus.inst_i[20:16];
        r_rd   <= bus.inst_i[15:11];
        r_imm  <= w_imm;
        r_load <= (w_op == OpLoad);
      end
    end
  end

  assign bus.v_o    = r_v;
  assign bus.op_o   = r_op;
  assign bus.rs_o   = r_rs;
  assign bus.rt_o   = r_rt;
  assign bus.rd_o   = r_rd;
  assign bus.imm_o  = r_imm;
  assign bus.load_o = r_load;
  assign bus.hcnt_o = r_hcnt;

endmodule
